// File: rtl/uc_pkg.sv
// Shared definitions for the UT control unit: opcodes, ALU selects, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uc_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

  // Same encoding the UT datapath decodes on its sel_UAL input.
  localparam logic [2:0] UAL_NOR = 3'b000;
  localparam logic [2:0] UAL_ADD = 3'b001;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    OPREAD,
    OPLOAD,
    EXEC,
    STORE,
    JUMP,
    HALT
  } state_t;

endpackage

// File: rtl/uc_sequencer_if.sv
// Sequencer-side bundle: memory port, UT strobes, control inputs and debug.
// Latency: n/a (wiring only).
// Backpressure: none; memory must hold read data while ce is low.
interface uc_sequencer_if;
  import uc_pkg::*;

  logic                ce;
  logic                start;
  logic                carry;
  logic [DATA_W-1:0]   mem_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_en;
  logic                mem_we;
  logic [2:0]          sel_UAL;
  logic                load_R1;
  logic                load_accu;
  logic                load_carry;
  logic                init_carry;
  logic [ADDR_W-1:0]   pc;
  logic                halted;

  // Sequencer side
  modport master (
    input  ce, start, carry, mem_rdata,
    output mem_addr, mem_en, mem_we, sel_UAL,
    output load_R1, load_accu, load_carry, init_carry, pc, halted
  );

  // Environment side (memory, UT, wrapper)
  modport slave (
    output ce, start, carry, mem_rdata,
    input  mem_addr, mem_en, mem_we, sel_UAL,
    input  load_R1, load_accu, load_carry, init_carry, pc, halted
  );

endinterface

// File: rtl/uc_sequencer.sv
// Multi-cycle fetch/decode/execute control unit driving the UT accumulator datapath.
// Latency: NOR/ADD 5 cycles, STA 3, JCC 3; next FETCH follows immediately.
// Backpressure: ce=0 freezes all state and forces every strobe to 0.
module uc_sequencer
  import uc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  uc_sequencer_if.master bus
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;

  logic [1:0]          ir_op;
  logic [ADDR_W-1:0]   ir_a;
  logic [ADDR_W-1:0]   pc_prev;
  logic                act;

  assign ir_op   = ir_q[7:6];
  assign ir_a    = ir_q[5:0];
  // PC already points past the JCC, so its own address is PC-1 (mod 64).
  assign pc_prev = pc_q - 6'd1;
  // Strobes are suppressed in a reset cycle so a pending STORE never reaches memory.
  assign act     = bus.ce && !rst;
  assign bus.pc  = pc_q;

  // State, PC and IR registers; reset wins over ce, ce=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else if (bus.ce) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC and IR update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d = bus.mem_rdata;
        pc_d = pc_q + 6'd1;
        case (bus.mem_rdata[7:6])
          OP_NOR, OP_ADD: state_d = OPREAD;
          OP_STA:         state_d = STORE;
          default:        state_d = JUMP;
        endcase
      end
      OPREAD: state_d = OPLOAD;
      OPLOAD: state_d = EXEC;
      EXEC:   state_d = FETCH;
      STORE:  state_d = FETCH;
      JUMP: begin
        // Branch on the carry value seen before UT clears it at this edge.
        if (!bus.carry) begin
          if (ir_a == pc_prev) begin
            state_d = HALT;
          end else begin
            pc_d    = ir_a;
            state_d = FETCH;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from state and IR, gated by ce and reset.
  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.sel_UAL    = UAL_NOR;
    bus.load_R1    = 1'b0;
    bus.load_accu  = 1'b0;
    bus.load_carry = 1'b0;
    bus.init_carry = 1'b0;
    bus.halted     = 1'b0;
    if (act) begin
      case (state_q)
        FETCH: begin
          bus.mem_addr = pc_q;
          bus.mem_en   = 1'b1;
        end
        OPREAD: begin
          bus.mem_addr = ir_a;
          bus.mem_en   = 1'b1;
        end
        OPLOAD: bus.load_R1 = 1'b1;
        EXEC: begin
          bus.sel_UAL    = (ir_op == OP_ADD) ? UAL_ADD : UAL_NOR;
          bus.load_accu  = 1'b1;
          bus.load_carry = (ir_op == OP_ADD);
        end
        STORE: begin
          bus.mem_addr = ir_a;
          bus.mem_en   = 1'b1;
          bus.mem_we   = 1'b1;
        end
        JUMP:    bus.init_carry = 1'b1;
        HALT:    bus.halted     = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer with a 64-byte memory model and an expected-output queue.
// Latency: n/a.
// Backpressure: exercises a ce gap in OPLOAD.
module tb_uc_sequencer;
  import uc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uc_sequencer_if bus ();
  uc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory model: synchronous read, data held while not requested.
  logic [7:0] mem [64];
  localparam logic [7:0] WDATA = 8'h5A;   // stands in for UT data_out
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= WDATA;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // {pc, halted, init_carry, load_carry, load_accu, load_R1, sel, we, en, addr}
  logic [21:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [21:0] obs();
    return {bus.pc, bus.halted, bus.init_carry, bus.load_carry, bus.load_accu,
            bus.load_R1, bus.sel_UAL, bus.mem_we, bus.mem_en, bus.mem_addr};
  endfunction

  task automatic push(input logic en, input logic we, input logic [5:0] a, input logic [2:0] sel,
                      input logic r1, input logic la, input logic lc, input logic ic,
                      input logic h, input logic [5:0] p);
    exp_q.push_back({p, h, ic, lc, la, r1, sel, we, en, a});
  endtask

  task automatic x_none(input logic [5:0] p);                     push(0,0,6'd0,3'b000,0,0,0,0,0,p); endtask
  task automatic x_fetch(input logic [5:0] p);                    push(1,0,p,   3'b000,0,0,0,0,0,p); endtask
  task automatic x_opread(input logic [5:0] a, input logic [5:0] p); push(1,0,a,3'b000,0,0,0,0,0,p); endtask
  task automatic x_opload(input logic [5:0] p);                   push(0,0,6'd0,3'b000,1,0,0,0,0,p); endtask
  task automatic x_exec(input logic add, input logic [5:0] p);    push(0,0,6'd0,{2'b00,add},0,1,add,0,0,p); endtask
  task automatic x_store(input logic [5:0] a, input logic [5:0] p); push(1,1,a,3'b000,0,0,0,0,0,p); endtask
  task automatic x_jump(input logic [5:0] p);                     push(0,0,6'd0,3'b000,0,0,0,1,0,p); endtask
  task automatic x_halt(input logic [5:0] p);                     push(0,0,6'd0,3'b000,0,0,0,0,1,p); endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag);
    logic [21:0] e;
    logic [21:0] o;
    #1;
    n_tests++;
    o = obs();
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s no expectation queued, observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic cyc(input string tag);
    step();
    chk(tag);
  endtask

  task automatic mem_chk(input string tag, input int a, input logic [7:0] v);
    n_tests++;
    assert (mem[a] === v) else begin
      n_fail++;
      $error("FAIL %s mem[%0d] observed=%h expected=%h", tag, a, mem[a], v);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.carry = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h45;   // ADD 5
    mem[1] = 8'h8A;   // STA 10
    mem[2] = 8'h03;   // NOR 3
    mem[3] = 8'hC0;   // JCC 0
    mem[4] = 8'hC3;   // JCC 3

    // Reset and idle
    x_none(0);  cyc("reset");
    rst = 1'b0;
    x_none(0);  cyc("idle_no_start");
    bus.start = 1'b1;

    // ADD 5 at address 0
    x_fetch(0);      cyc("add_fetch");
    x_none(0);       cyc("add_decode");
    x_opread(5, 1);  cyc("add_opread");
    x_opload(1);     cyc("add_opload");
    x_exec(1, 1);    cyc("add_exec");

    // STA 10 at address 1
    x_fetch(1);      cyc("sta_fetch");
    x_none(1);       cyc("sta_decode");
    x_store(10, 2);  cyc("sta_store");
    x_fetch(2);      cyc("sta_next_fetch");
    mem_chk("sta_write", 10, WDATA);

    // NOR 3 at address 2 with a 3-cycle ce gap in OPLOAD
    x_none(2);       cyc("nor_decode");
    x_opread(3, 3);  cyc("nor_opread");
    step(); bus.ce = 1'b0; x_none(3); chk("gap_0");
    step();                x_none(3); chk("gap_1");
    step();                x_none(3); chk("gap_2");
    step(); bus.ce = 1'b1; x_opload(3); chk("gap_resume_opload");
    x_exec(0, 3);    cyc("nor_exec");

    // JCC 0 at address 3, carry = 1: falls through to 4
    x_fetch(3);      cyc("jcc_c1_fetch");
    x_none(3);       cyc("jcc_c1_decode");
    bus.carry = 1'b1;
    x_jump(4);       cyc("jcc_c1_jump");
    x_fetch(4);      cyc("jcc_c1_next_fetch");
    bus.carry = 1'b0;

    // JCC 3 at address 4, carry = 0: jumps back to 3
    x_none(4);       cyc("jcc_to3_decode");
    x_jump(5);       cyc("jcc_to3_jump");
    x_fetch(3);      cyc("jcc_to3_fetch");

    // JCC 0 at address 3, carry = 0: jumps to 0
    x_none(3);       cyc("jcc_c0_decode");
    x_jump(4);       cyc("jcc_c0_jump");
    x_fetch(0);      cyc("jcc_c0_fetch0");

    // Re-run ADD, then reset in the middle of STORE
    x_none(0);       cyc("add2_decode");
    x_opread(5, 1);  cyc("add2_opread");
    x_opload(1);     cyc("add2_opload");
    x_exec(1, 1);    cyc("add2_exec");
    x_fetch(1);      cyc("sta2_fetch");
    x_none(1);       cyc("sta2_decode");
    mem[10] = 8'h00;
    x_store(10, 2);  cyc("sta2_store");
    rst = 1'b1;
    x_none(0);       cyc("rst_in_store");
    mem_chk("store_dropped", 10, 8'h00);

    // Jump-to-self HALT: 0: JCC 7, 7: JCC 7
    mem[0] = 8'hC7;
    mem[7] = 8'hC7;
    rst = 1'b0;
    x_fetch(0);      cyc("h_fetch0");
    x_none(0);       cyc("h_decode0");
    x_jump(1);       cyc("h_jump0");
    x_fetch(7);      cyc("h_fetch7");
    x_none(7);       cyc("h_decode7");
    x_jump(8);       cyc("h_jump7");
    for (int i = 0; i < 20; i++) begin
      bus.start = i[0];
      x_halt(8);     cyc("halt_hold");
    end
    rst = 1'b1;
    x_none(0);       cyc("halt_reset");

    // Modulo-64 self jump: 0: JCC 63, 63: JCC 63 (PC wraps to 0)
    mem[0]  = 8'hFF;
    mem[63] = 8'hFF;
    rst = 1'b0;
    bus.start = 1'b1;
    x_fetch(0);      cyc("w_fetch0");
    x_none(0);       cyc("w_decode0");
    x_jump(1);       cyc("w_jump0");
    x_fetch(63);     cyc("w_fetch63");
    x_none(63);      cyc("w_decode63");
    x_jump(0);       cyc("w_jump63");
    x_halt(0);       cyc("w_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
